// File: rtl/btb_fetch_ctrl.sv
// btb_fetch_ctrl: BTB-driven fetch PC generator with an in-flight prediction queue, resolve check and redirect
module btb_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        btb_valid,
    input  logic [31:0] btb_target,
    input  logic        btb_taken,
    input  logic        resolve_valid,
    input  logic        resolve_is_branch,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    output logic [31:0] PC,
    output logic        fetch_valid,
    output logic        q_full,
    output logic        q_empty,
    output logic        update,
    output logic [31:0] updatePC,
    output logic [31:0] updateTarget,
    output logic        mispredicted
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    logic [31:0]       q_pc     [QDEPTH];
    logic [31:0]       q_target [QDEPTH];
    logic [QDEPTH-1:0] q_taken;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              pred_taken, resolve_ok, mispredict, pop, upd_trig;
    logic [31:0]       pc_next;
    assign q_empty = count == '0;
    assign q_full  = count == CW'(QDEPTH);
    // Prediction, resolve check and next PC: redirect beats fetch advance, fetch advance beats hold
    always_comb begin
        pred_taken  = btb_valid & btb_taken;
        resolve_ok  = resolve_valid & ~q_empty;
        mispredict  = resolve_ok & ((resolve_taken != q_taken[rd_ptr]) |
                      (resolve_taken & (resolve_target != q_target[rd_ptr])));
        upd_trig    = resolve_ok & (resolve_is_branch | mispredict);
        fetch_valid = ~stall & ~q_full & ~mispredict;
        pop         = resolve_ok & ~mispredict;
        pc_next     = mispredict  ? (resolve_taken ? resolve_target : q_pc[rd_ptr] + 32'd4) :
                      fetch_valid ? (pred_taken ? btb_target : PC + 32'd4) : PC;
    end
    // Control state: PC, queue occupancy and the registered BTB update port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= RESET_PC;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            update       <= 1'b0;
            mispredicted <= 1'b0;
            updatePC     <= '0;
            updateTarget <= '0;
        end else begin
            PC           <= pc_next;
            update       <= upd_trig;
            mispredicted <= mispredict;
            if (upd_trig) begin
                updatePC     <= q_pc[rd_ptr];
                updateTarget <= resolve_target;
            end
            if (mispredict) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (fetch_valid) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(fetch_valid) - CW'(pop);
            end
        end
    end
    // Entry storage needs no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (fetch_valid) begin
            q_pc[wr_ptr]     <= PC;
            q_taken[wr_ptr]  <= pred_taken;
            q_target[wr_ptr] <= btb_target;
        end
    end
endmodule
